// File: rtl/fm_param_ctrl.sv
// fm_param_ctrl: parameter sequencer in front of the fm synthesizer.
// Commands land in shadow registers; all three synth parameters change together
// on a sample_tick, with optional linear glide of the fundamental.
// Optional feature macro: FM_PARAM_CLAMP_EN (clamps fundamental targets to FUND_MAX).
module fm_param_ctrl #(
  parameter logic [23:0] FUND_RESET = 24'd450560,
  parameter logic [15:0] HARM_RESET = 16'h2000,
  parameter logic [15:0] MIDX_RESET = 16'h0000,
  parameter logic [23:0] FUND_MAX   = 24'd12288000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_addr,
  input  logic [23:0] cmd_data,
  input  logic        sample_tick,
  output logic [23:0] fundamental,
  output logic [15:0] harmonicity,
  output logic [15:0] mod_index,
  output logic        busy,
  output logic        done
);

  localparam int unsigned FW = 24;
  localparam int unsigned PW = 16;
  localparam int unsigned DW = FW + 1;

  typedef enum logic [1:0] {IDLE, PENDING, GLIDE} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] fund_q, fund_d, tgt_q, tgt_d, step_sh_q, step_sh_d;
  logic [PW-1:0] harm_q, harm_d, midx_q, midx_d;
  logic [PW-1:0] harm_sh_q, harm_sh_d, midx_sh_q, midx_sh_d;
  logic          done_q, done_d, ready_q, ready_d, busy_q, busy_d;

  logic          accept;
  logic          up;
  logic [FW-1:0] tgt_in;
  logic [DW-1:0] fund_x, tgt_x, step_x, diff;

`ifndef FM_PARAM_CLAMP_EN
  logic unused_fund_max_c;
  assign unused_fund_max_c = ^FUND_MAX;
`endif

  // State and parameter registers; reset abandons any pending or gliding operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      fund_q    <= FUND_RESET;
      harm_q    <= HARM_RESET;
      midx_q    <= MIDX_RESET;
      tgt_q     <= FUND_RESET;
      harm_sh_q <= HARM_RESET;
      midx_sh_q <= MIDX_RESET;
      step_sh_q <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fund_q    <= fund_d;
      harm_q    <= harm_d;
      midx_q    <= midx_d;
      tgt_q     <= tgt_d;
      harm_sh_q <= harm_sh_d;
      midx_sh_q <= midx_sh_d;
      step_sh_q <= step_sh_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state: shadow writes, commit on tick, glide stepping toward target
  always_comb begin
    state_d   = state_q;
    fund_d    = fund_q;
    harm_d    = harm_q;
    midx_d    = midx_q;
    tgt_d     = tgt_q;
    harm_sh_d = harm_sh_q;
    midx_sh_d = midx_sh_q;
    step_sh_d = step_sh_q;
    done_d    = 1'b0;

    accept = cmd_valid && ready_q;
`ifdef FM_PARAM_CLAMP_EN
    tgt_in = (cmd_data > FUND_MAX) ? FUND_MAX : cmd_data;
`else
    tgt_in = cmd_data;
`endif
    fund_x = {1'b0, fund_q};
    tgt_x  = {1'b0, tgt_q};
    step_x = {1'b0, step_sh_q};
    up     = tgt_q > fund_q;
    diff   = up ? (tgt_x - fund_x) : (fund_x - tgt_x);

    // Shadow updates; the tick logic below still sees the old tgt_q/step_sh_q
    if (accept) begin
      unique case (cmd_addr)
        2'd0:    tgt_d     = tgt_in;
        2'd1:    harm_sh_d = cmd_data[PW-1:0];
        2'd2:    midx_sh_d = cmd_data[PW-1:0];
        default: step_sh_d = cmd_data;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (accept && cmd_addr == 2'd0) state_d = PENDING;
      end
      PENDING: begin
        if (sample_tick) begin
          harm_d = harm_sh_q;
          midx_d = midx_sh_q;
          if (step_sh_q == '0 || tgt_q == fund_q) begin
            fund_d  = tgt_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = GLIDE;
          end
        end
      end
      GLIDE: begin
        if (sample_tick) begin
          if (diff <= step_x) begin
            fund_d  = tgt_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (up) begin
            fund_d = FW'(fund_x + step_x);
          end else begin
            fund_d = FW'(fund_x - step_x);
          end
        end
        if (accept && cmd_addr == 2'd0) state_d = PENDING;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d != PENDING);
    busy_d  = (state_d != IDLE);
  end

  assign fundamental = fund_q;
  assign harmonicity = harm_q;
  assign mod_index   = midx_q;
  assign cmd_ready   = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fm_param_ctrl.sv
// Self-checking bench for fm_param_ctrl: directed scenarios plus randomized
// glides checked against an arithmetic model of the ramp.
module tb_fm_param_ctrl;

  localparam logic [23:0] FUND_RST = 24'd450560;
  localparam logic [15:0] HARM_RST = 16'h2000;
  localparam logic [15:0] MIDX_RST = 16'h0000;
  localparam logic [23:0] FMAX     = 24'd12288000;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, sample_tick, busy, done;
  logic [1:0]  cmd_addr;
  logic [23:0] cmd_data, fundamental;
  logic [15:0] harmonicity, mod_index;

  int n_cmp = 0;
  int n_fail = 0;

  // model state (expected outputs when idle)
  logic [23:0] m_fund;
  logic [15:0] m_harm, m_midx;

  fm_param_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .sample_tick(sample_tick),
    .fundamental(fundamental), .harmonicity(harmonicity), .mod_index(mod_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick;
    sample_tick = 1'b1;
    step_clk();
    sample_tick = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [23:0] d);
    int w;
    w = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && w < 20) begin step_clk(); w++; end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_ready_timeout: got %b exp 1", cmd_ready);
    end else step_clk();
    cmd_valid = 1'b0;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    step_clk(); step_clk();
    reset = 1'b1;
    step_clk();
    m_fund = FUND_RST; m_harm = HARM_RST; m_midx = MIDX_RST;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step_clk(); step_clk();
    reset = 1'b1;
    step_clk(); step_clk();
    m_fund = FUND_RST; m_harm = HARM_RST; m_midx = MIDX_RST;
    n_cmp++; if (fundamental !== FUND_RST) begin n_fail++; $display("FAIL rst_fund: got %0d exp %0d", fundamental, FUND_RST); end
    n_cmp++; if (harmonicity !== HARM_RST) begin n_fail++; $display("FAIL rst_harm: got %h exp %h", harmonicity, HARM_RST); end
    n_cmp++; if (mod_index !== MIDX_RST) begin n_fail++; $display("FAIL rst_midx: got %h exp %h", mod_index, MIDX_RST); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", cmd_ready); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b exp 0", done); end
    // idle ticks are ignored
    do_tick(); do_tick();
    n_cmp++; if (fundamental !== FUND_RST || done !== 1'b0) begin n_fail++; $display("FAIL idle_tick: got %0d/%b exp %0d/0", fundamental, done, FUND_RST); end
  endtask

  task automatic test_commit;
    wr(2'd1, 24'hAB4000); wr(2'd2, 24'h000400); wr(2'd3, 24'd0); wr(2'd0, 24'd900000);
    n_cmp++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL commit_pend: got busy=%b rdy=%b exp 1/0", busy, cmd_ready); end
    step_clk();
    n_cmp++; if (fundamental !== FUND_RST || harmonicity !== HARM_RST || mod_index !== MIDX_RST) begin
      n_fail++; $display("FAIL commit_shadow: got %0d/%h/%h exp unchanged", fundamental, harmonicity, mod_index); end
    do_tick();
    n_cmp++; if (fundamental !== 24'd900000 || harmonicity !== 16'h4000 || mod_index !== 16'h0400) begin
      n_fail++; $display("FAIL commit_out: got %0d/%h/%h exp 900000/4000/0400", fundamental, harmonicity, mod_index); end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL commit_done: got done=%b busy=%b exp 1/0", done, busy); end
    step_clk();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL commit_done_pulse: got %b exp 0", done); end
    m_fund = 24'd900000; m_harm = 16'h4000; m_midx = 16'h0400;
  endtask

  task automatic test_glide_up;
    logic [23:0] exp_v [3];
    exp_v[0] = 24'd550560; exp_v[1] = 24'd650560; exp_v[2] = 24'd700000;
    apply_reset();
    wr(2'd3, 24'd100000); wr(2'd0, 24'd700000);
    do_tick();
    n_cmp++; if (fundamental !== FUND_RST || done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL glide_commit_tick: got %0d done=%b rdy=%b busy=%b exp %0d/0/1/1", fundamental, done, cmd_ready, busy, FUND_RST); end
    for (int k = 0; k < 3; k++) begin
      do_tick();
      n_cmp++; if (fundamental !== exp_v[k] || done !== (k == 2)) begin
        n_fail++; $display("FAIL glide_up_%0d: got %0d done=%b exp %0d done=%b", k, fundamental, done, exp_v[k], k == 2); end
    end
    m_fund = 24'd700000;
  endtask

  task automatic test_glide_down_big_step;
    apply_reset();
    wr(2'd3, 24'h800000); wr(2'd0, 24'd100);
    do_tick(); do_tick();
    n_cmp++; if (fundamental !== 24'd100 || done !== 1'b1) begin
      n_fail++; $display("FAIL glide_down_land: got %0d done=%b exp 100 done=1", fundamental, done); end
    m_fund = 24'd100;
  endtask

  task automatic test_retarget_on_tick;
    logic [23:0] exp_v [5];
    exp_v[0] = 24'd550560; exp_v[1] = 24'd450560; exp_v[2] = 24'd350560;
    exp_v[3] = 24'd250560; exp_v[4] = 24'd200000;
    apply_reset();
    wr(2'd3, 24'd100000); wr(2'd0, 24'd900000);
    do_tick(); do_tick();
    n_cmp++; if (fundamental !== 24'd550560) begin n_fail++; $display("FAIL retgt_pre: got %0d exp 550560", fundamental); end
    cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_data = 24'd200000; sample_tick = 1'b1;
    step_clk();
    cmd_valid = 1'b0; sample_tick = 1'b0;
    n_cmp++; if (fundamental !== 24'd650560 || cmd_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL retgt_old_step: got %0d rdy=%b busy=%b done=%b exp 650560/0/1/0", fundamental, cmd_ready, busy, done); end
    step_clk();
    n_cmp++; if (fundamental !== 24'd650560 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL retgt_pending: got %0d rdy=%b exp 650560/0", fundamental, cmd_ready); end
    do_tick();
    n_cmp++; if (fundamental !== 24'd650560 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL retgt_commit: got %0d rdy=%b done=%b exp 650560/1/0", fundamental, cmd_ready, done); end
    for (int k = 0; k < 5; k++) begin
      do_tick();
      n_cmp++; if (fundamental !== exp_v[k] || done !== (k == 4)) begin
        n_fail++; $display("FAIL retgt_ramp_%0d: got %0d done=%b exp %0d done=%b", k, fundamental, done, exp_v[k], k == 4); end
    end
    m_fund = 24'd200000;
  endtask

  task automatic test_idle_tick_cmd;
    wr(2'd3, 24'd0);
    cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_data = 24'd123456; sample_tick = 1'b1;
    step_clk();
    cmd_valid = 1'b0; sample_tick = 1'b0;
    n_cmp++; if (fundamental !== m_fund || busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL idle_tick_cmd_latch: got %0d busy=%b rdy=%b done=%b exp %0d/1/0/0", fundamental, busy, cmd_ready, done, m_fund); end
    do_tick();
    n_cmp++; if (fundamental !== 24'd123456 || done !== 1'b1) begin
      n_fail++; $display("FAIL idle_tick_cmd_commit: got %0d done=%b exp 123456/1", fundamental, done); end
    m_fund = 24'd123456;
  endtask

  task automatic test_glide_random;
    longint f0, t, s, diff, n, e;
    logic [15:0] h, m;
    for (int it = 0; it < 12; it++) begin
      f0 = longint'(m_fund);
      t  = longint'($urandom_range(0, 24'hFFFFFF));
      if (it == 7) t = f0;
      h = 16'($urandom); m = 16'($urandom);
      diff = (t > f0) ? t - f0 : f0 - t;
      case (it % 4)
        0:       s = 0;
        1:       s = (diff == 0) ? 1 : diff;
        default: s = diff / longint'($urandom_range(2, 12)) + 1;
      endcase
      wr(2'd1, {8'($urandom), h}); wr(2'd2, {8'($urandom), m}); wr(2'd3, 24'(s)); wr(2'd0, 24'(t));
      repeat ($urandom_range(0, 3)) step_clk();
      do_tick();
      n_cmp++; if (harmonicity !== h || mod_index !== m) begin
        n_fail++; $display("FAIL rnd%0d_params: got %h/%h exp %h/%h", it, harmonicity, mod_index, h, m); end
      if (s == 0 || diff == 0) begin
        n_cmp++; if (fundamental !== 24'(t) || done !== 1'b1) begin
          n_fail++; $display("FAIL rnd%0d_direct: got %0d done=%b exp %0d done=1", it, fundamental, done, t); end
      end else begin
        n_cmp++; if (fundamental !== 24'(f0) || done !== 1'b0) begin
          n_fail++; $display("FAIL rnd%0d_nostep: got %0d done=%b exp %0d done=0", it, fundamental, done, f0); end
        n = (diff + s - 1) / s;
        for (longint k = 1; k <= n; k++) begin
          if ($urandom_range(0, 1) == 1) step_clk();
          do_tick();
          e = (k == n) ? t : ((t > f0) ? f0 + k * s : f0 - k * s);
          n_cmp++; if (fundamental !== 24'(e) || done !== (k == n)) begin
            n_fail++; $display("FAIL rnd%0d_ramp%0d: got %0d done=%b exp %0d done=%b", it, k, fundamental, done, e, k == n); end
        end
      end
      step_clk();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_idle: got done=%b busy=%b exp 0/0", it, done, busy); end
      m_fund = 24'(t); m_harm = h; m_midx = m;
    end
  endtask

  task automatic test_reset_mid_glide;
    apply_reset();
    wr(2'd1, 24'h001234); wr(2'd3, 24'd1000); wr(2'd0, 24'd900000);
    do_tick(); do_tick(); do_tick();
    n_cmp++; if (busy !== 1'b1 || harmonicity !== 16'h1234) begin
      n_fail++; $display("FAIL midglide_pre: got busy=%b harm=%h exp 1/1234", busy, harmonicity); end
    reset = 1'b0;
    #1;
    n_cmp++; if (fundamental !== FUND_RST || harmonicity !== HARM_RST || mod_index !== MIDX_RST || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL midglide_reset: got %0d/%h/%h busy=%b rdy=%b exp reset values", fundamental, harmonicity, mod_index, busy, cmd_ready); end
    step_clk();
    reset = 1'b1;
    step_clk();
    do_tick(); do_tick();
    n_cmp++; if (fundamental !== FUND_RST || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midglide_after: got %0d busy=%b done=%b exp %0d/0/0", fundamental, busy, done, FUND_RST); end
    m_fund = FUND_RST; m_harm = HARM_RST; m_midx = MIDX_RST;
  endtask

  task automatic test_clamp;
    logic [23:0] e;
`ifdef FM_PARAM_CLAMP_EN
    e = FMAX;
`else
    e = 24'd16000000;
`endif
    wr(2'd3, 24'd0); wr(2'd0, 24'd16000000);
    do_tick();
    n_cmp++; if (fundamental !== e || done !== 1'b1) begin
      n_fail++; $display("FAIL clamp: got %0d done=%b exp %0d done=1", fundamental, done, e); end
    m_fund = e;
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_data = '0; sample_tick = 1'b0;
    test_reset();
    test_commit();
    test_glide_up();
    test_glide_down_big_step();
    test_retarget_on_tick();
    test_idle_tick_cmd();
    test_glide_random();
    test_reset_mid_glide();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
